// File: rtl/pixel_loader.sv
// Purpose: deserialises a synced byte stream (AA 55 header) into addressed pixel writes for a frame buffer.
// Latency: one cycle from an accepted pixel byte to its o_DV/o_pixel/o_col/o_row write strobe.
// Backpressure: none; every i_DV is consumed or dropped, and an inter-byte stall aborts the frame via timeout.
module pixel_loader #(
    parameter int bitsPixel     = 8,
    parameter int numPixel      = 19200,
    parameter int lineWidth     = 160,
    parameter int timeoutCycles = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_DV,
    input  logic [bitsPixel-1:0] i_byte,
    output logic                 o_DV,
    output logic [bitsPixel-1:0] o_pixel,
    output logic [7:0]           o_col,
    output logic [6:0]           o_row,
    output logic                 o_frameDone,
    output logic                 o_err,
    output logic                 o_busy
);

    // Header bytes, sized to the pixel width so the compare is width-clean.
    localparam logic [bitsPixel-1:0] SYNC_A = bitsPixel'(8'hAA);
    localparam logic [bitsPixel-1:0] SYNC_B = bitsPixel'(8'h55);

    // Last column of a row and last pixel of a frame.
    localparam logic [7:0]  COL_LAST = 8'(lineWidth - 1);
    localparam logic [14:0] PIX_LAST = 15'(numPixel - 1);

    // Idle counter only has to reach the timeout value, then it stops.
    localparam int                IDLE_W   = $clog2(timeoutCycles + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(timeoutCycles);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [14:0]       pix_cnt;
    logic [7:0]        col_cnt;
    logic [6:0]        row_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    // Decoded per-cycle controls, produced by the output decode below.
    logic timeout_fire;
    logic load_start;
    logic pix_accept;
    logic frame_last;

    // State register; reset forces IDLE so any partial frame is abandoned silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: timeout has priority over any byte arriving the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_DV && (i_byte == SYNC_A)) begin
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (timeout_fire) begin
                    state_nxt = ST_IDLE;
                end else if (i_DV) begin
                    if (i_byte == SYNC_B) begin
                        state_nxt = ST_LOAD;
                    end else if (i_byte == SYNC_A) begin
                        state_nxt = ST_SYNC;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_LOAD: begin
                if (timeout_fire) begin
                    state_nxt = ST_IDLE;
                end else if (i_DV && frame_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: busy flag plus the strobes that steer the datapath registers.
    always_comb begin
        o_busy       = (state != ST_IDLE);
        timeout_fire = (state != ST_IDLE) && (idle_cnt == IDLE_MAX);
        load_start   = (state == ST_SYNC) && i_DV && !timeout_fire && (i_byte == SYNC_B);
        pix_accept   = (state == ST_LOAD) && i_DV && !timeout_fire;
        frame_last   = (pix_cnt == PIX_LAST);
    end

    // Idle counter: cleared by any byte and while IDLE (so SYNC entry starts from zero), saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state == ST_IDLE) || i_DV || timeout_fire) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Pixel/column/row counters; row*lineWidth+col always tracks pix_cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (timeout_fire || load_start) begin
            pix_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_accept) begin
            if (frame_last) begin
                pix_cnt <= '0;
                col_cnt <= '0;
                row_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + 15'd1;
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 7'd1;
                end else begin
                    col_cnt <= col_cnt + 8'd1;
                end
            end
        end
    end

    // Registered write port: strobes are single-cycle, data/address hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_DV        <= 1'b0;
            o_pixel     <= '0;
            o_col       <= '0;
            o_row       <= '0;
            o_frameDone <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_DV        <= pix_accept;
            o_frameDone <= pix_accept && frame_last;
            o_err       <= timeout_fire;
            if (pix_accept) begin
                o_pixel <= i_byte;
                o_col   <= col_cnt;
                o_row   <= row_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pixel_loader.sv
module tb_pixel_loader;

    localparam int BP = 8;
    localparam int NP = 8;
    localparam int LW = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_DV;
    logic [7:0] i_byte;
    logic       o_DV;
    logic [7:0] o_pixel;
    logic [7:0] o_col;
    logic [6:0] o_row;
    logic       o_frameDone;
    logic       o_err;
    logic       o_busy;

    always #5 clk = ~clk;

    pixel_loader #(
        .bitsPixel    (BP),
        .numPixel     (NP),
        .lineWidth    (LW),
        .timeoutCycles(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_DV       (i_DV),
        .i_byte     (i_byte),
        .o_DV       (o_DV),
        .o_pixel    (o_pixel),
        .o_col      (o_col),
        .o_row      (o_row),
        .o_frameDone(o_frameDone),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic       rst_n;
        logic       dv;
        logic [7:0] byt;
        logic       e_dv;
        logic [7:0] e_pix;
        logic [7:0] e_col;
        logic [6:0] e_row;
        logic       e_fd;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Control byte or idle cycle: no write expected.
    function automatic vec_t V(input logic dv, input logic [7:0] b, input logic busy);
        vec_t v;
        v.rst_n = 1'b1; v.dv = dv; v.byt = b;
        v.e_dv = 1'b0; v.e_pix = 8'h00; v.e_col = 8'h00; v.e_row = 7'h00;
        v.e_fd = 1'b0; v.e_err = 1'b0; v.e_busy = busy;
        return v;
    endfunction

    // Pixel byte in LOAD: written one cycle later at (col,row).
    function automatic vec_t P(input logic [7:0] b, input int col, input int row, input logic fd);
        vec_t v;
        v.rst_n = 1'b1; v.dv = 1'b1; v.byt = b;
        v.e_dv = 1'b1; v.e_pix = b; v.e_col = 8'(col); v.e_row = 7'(row);
        v.e_fd = fd; v.e_err = 1'b0; v.e_busy = !fd;
        return v;
    endfunction

    // Cycle on which the timeout fires: error pulse, no write, back to IDLE.
    function automatic vec_t T(input logic dv, input logic [7:0] b);
        vec_t v;
        v = V(dv, b, 1'b0);
        v.e_err = 1'b1;
        return v;
    endfunction

    // Reset cycle: everything zero regardless of i_DV.
    function automatic vec_t R(input logic dv, input logic [7:0] b);
        vec_t v;
        v = V(dv, b, 1'b0);
        v.rst_n = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n  = v.rst_n;
        i_DV   = v.dv;
        i_byte = v.byt;
        @(posedge clk);
        #1;
        chk("o_DV",        idx, 32'(o_DV),        32'(v.e_dv));
        chk("o_frameDone", idx, 32'(o_frameDone), 32'(v.e_fd));
        chk("o_err",       idx, 32'(o_err),       32'(v.e_err));
        chk("o_busy",      idx, 32'(o_busy),      32'(v.e_busy));
        if (v.e_dv || !v.rst_n) begin
            chk("o_pixel", idx, 32'(o_pixel), 32'(v.e_pix));
            chk("o_col",   idx, 32'(o_col),   32'(v.e_col));
            chk("o_row",   idx, 32'(o_row),   32'(v.e_row));
        end
    endtask

    // Drive without expectations (used where the bench counts pulses instead).
    task automatic drive(input logic dv, input logic [7:0] b);
        @(negedge clk);
        rst_n  = 1'b1;
        i_DV   = dv;
        i_byte = b;
        @(posedge clk);
        #1;
    endtask

    // Full synced frame with back-to-back bytes; also checks the write strobe stays high all 8 cycles.
    task automatic run_frame(input logic [7:0] base, input int tag);
        int run = 0;
        apply(V(1'b1, 8'hAA, 1'b1), tag);
        apply(V(1'b1, 8'h55, 1'b1), tag);
        for (int i = 0; i < 8; i++) begin
            apply(P(8'(base + 8'(i)), i % 4, i / 4, i == 7), tag + i + 1);
            if (o_DV === 1'b1) run++;
        end
        chk("dv_run", tag, 32'(run), 32'd8);
    endtask

    initial begin
        int err_cnt;
        int fd_cnt;
        int err_pos;

        rst_n  = 1'b0;
        i_DV   = 1'b0;
        i_byte = 8'h00;

        // Reset with a sync byte on the bus: ignored.
        tbl.push_back(R(1'b1, 8'hAA));
        tbl.push_back(V(1'b0, 8'h00, 1'b0));

        // Basic frame 10..17, busy drops with frameDone and stays low.
        tbl.push_back(V(1'b1, 8'hAA, 1'b1));
        tbl.push_back(V(1'b1, 8'h55, 1'b1));
        tbl.push_back(P(8'h10, 0, 0, 1'b0));
        tbl.push_back(P(8'h11, 1, 0, 1'b0));
        tbl.push_back(P(8'h12, 2, 0, 1'b0));
        tbl.push_back(P(8'h13, 3, 0, 1'b0));
        tbl.push_back(P(8'h14, 0, 1, 1'b0));
        tbl.push_back(P(8'h15, 1, 1, 1'b0));
        tbl.push_back(P(8'h16, 2, 1, 1'b0));
        tbl.push_back(P(8'h17, 3, 1, 1'b1));
        tbl.push_back(V(1'b0, 8'h00, 1'b0));

        // Sync-valued bytes inside LOAD are data.
        tbl.push_back(V(1'b1, 8'hAA, 1'b1));
        tbl.push_back(V(1'b1, 8'h55, 1'b1));
        tbl.push_back(P(8'hAA, 0, 0, 1'b0));
        tbl.push_back(P(8'h55, 1, 0, 1'b0));
        for (int i = 2; i < 8; i++) tbl.push_back(P(8'(8'h20 + 8'(i)), i % 4, i / 4, i == 7));

        // Repeated AA keeps SYNC, then lock on 55.
        tbl.push_back(V(1'b1, 8'hAA, 1'b1));
        tbl.push_back(V(1'b1, 8'hAA, 1'b1));
        tbl.push_back(V(1'b1, 8'h55, 1'b1));
        for (int i = 0; i < 8; i++) tbl.push_back(P(8'(8'h01 + 8'(i)), i % 4, i / 4, i == 7));

        // Stray byte in IDLE ignored; non-sync byte in SYNC falls back to IDLE; lone 55 ignored.
        tbl.push_back(V(1'b1, 8'h13, 1'b0));
        tbl.push_back(V(1'b1, 8'hAA, 1'b1));
        tbl.push_back(V(1'b1, 8'h12, 1'b0));
        tbl.push_back(V(1'b1, 8'h55, 1'b0));

        // Timeout while waiting in SYNC: 16 quiet cycles tolerated, fires on the 17th.
        tbl.push_back(V(1'b1, 8'hAA, 1'b1));
        for (int i = 0; i < TO; i++) tbl.push_back(V(1'b0, 8'h00, 1'b1));
        tbl.push_back(T(1'b0, 8'h00));
        tbl.push_back(V(1'b0, 8'h00, 1'b0));

        foreach (tbl[k]) apply(tbl[k], k);

        // Timeout in LOAD after three pixels: exactly one error pulse, no frameDone.
        apply(V(1'b1, 8'hAA, 1'b1), 1000);
        apply(V(1'b1, 8'h55, 1'b1), 1001);
        apply(P(8'h30, 0, 0, 1'b0), 1002);
        apply(P(8'h31, 1, 0, 1'b0), 1003);
        apply(P(8'h32, 2, 0, 1'b0), 1004);
        err_cnt = 0;
        fd_cnt  = 0;
        err_pos = -1;
        for (int j = 1; j <= 20; j++) begin
            drive(1'b0, 8'h00);
            if (o_err === 1'b1) begin
                err_cnt++;
                if (err_pos < 0) err_pos = j;
            end
            if (o_frameDone === 1'b1) fd_cnt++;
        end
        chk("load_timeout_err_count", 1005, 32'(err_cnt), 32'd1);
        chk("load_timeout_err_cycle", 1006, 32'(err_pos), 32'd17);
        chk("load_timeout_fd_count",  1007, 32'(fd_cnt),  32'd0);
        chk("load_timeout_busy",      1008, 32'(o_busy),  32'd0);
        run_frame(8'h40, 1100);

        // A byte arriving on the timeout cycle is dropped; new frame accepted right after.
        apply(V(1'b1, 8'hAA, 1'b1), 1200);
        apply(V(1'b1, 8'h55, 1'b1), 1201);
        apply(P(8'h50, 0, 0, 1'b0), 1202);
        apply(P(8'h51, 1, 0, 1'b0), 1203);
        for (int i = 0; i < TO; i++) apply(V(1'b0, 8'h00, 1'b1), 1204 + i);
        apply(T(1'b1, 8'h99), 1230);
        run_frame(8'h60, 1300);

        // Reset mid-LOAD: silent abort, stale pixel bytes ignored until a fresh sync.
        apply(V(1'b1, 8'hAA, 1'b1), 1400);
        apply(V(1'b1, 8'h55, 1'b1), 1401);
        for (int i = 0; i < 5; i++) apply(P(8'(8'h70 + 8'(i)), i % 4, i / 4, 1'b0), 1402 + i);
        apply(R(1'b1, 8'h44), 1410);
        apply(V(1'b1, 8'h33, 1'b0), 1411);
        apply(V(1'b0, 8'h00, 1'b0), 1412);
        run_frame(8'h80, 1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
